// File: rtl/nco_phase_acc.sv
// NCO phase generator: a 32-bit tuning-word accumulator with a double-buffered frequency
// register, optional LFSR phase dither, a phase offset, and a truncated Theta output for the LUT.
module nco_phase_acc #(
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned OUT_W     = 10,
  parameter int unsigned DITHER_W  = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_en_i,
  input  logic [ACC_W-1:0] freq_word_i,
  input  logic             freq_load_i,
  output logic             freq_ack_o,
  input  logic [OUT_W-1:0] phase_offset_i,
  input  logic             phase_sync_i,
  input  logic             dither_en_i,
  output logic [OUT_W-1:0] theta_o,
  output logic             theta_valid_o,
  output logic             wrap_o
);

  localparam int unsigned T_W = OUT_W + DITHER_W;
  // Galois taps for x^16+x^14+x^13+x^11+1 in right-shift form.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] active_freq_q, active_freq_d;
  logic [ACC_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [OUT_W-1:0] theta_q, theta_d;
  logic             theta_valid_q, theta_valid_d;
  logic             wrap_q, wrap_d;
  logic             freq_ack_q, freq_ack_d;

  logic [ACC_W:0]   sum;
  logic [T_W-1:0]   dither_add;
  logic [T_W-1:0]   t_phase;
  logic [15:0]      lfsr_step;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    acc_d         = acc_q;
    active_freq_d = active_freq_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    lfsr_d        = lfsr_q;
    theta_d       = theta_q;

    sum        = {1'b0, acc_q} + {1'b0, active_freq_q};
    dither_add = dither_en_i ? {{OUT_W{1'b0}}, lfsr_q[DITHER_W-1:0]} : '0;
    t_phase    = acc_q[ACC_W-1 -: T_W] + dither_add;
    lfsr_step  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    theta_valid_d = clk_en_i;
    freq_ack_d    = clk_en_i && pending_q;
    wrap_d        = clk_en_i && !phase_sync_i && sum[ACC_W];

    if (clk_en_i) begin
      // Output uses the pre-update acc and lfsr, so Theta lags acc by one enabled cycle.
      theta_d = t_phase[T_W-1 -: OUT_W] + phase_offset_i;
      acc_d   = phase_sync_i ? '0 : sum[ACC_W-1:0];
      lfsr_d  = lfsr_step;
      if (pending_q) begin
        active_freq_d = shadow_q;
        pending_d     = 1'b0;
      end
    end

    // A same-cycle load lands after the transfer: active takes the old shadow, pending re-arms.
    if (freq_load_i) begin
      shadow_d  = freq_word_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst_i) begin
      acc_q         <= '0;
      active_freq_q <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      lfsr_q        <= LFSR_SEED;
      theta_q       <= '0;
      theta_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
      freq_ack_q    <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      active_freq_q <= active_freq_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      lfsr_q        <= lfsr_d;
      theta_q       <= theta_d;
      theta_valid_q <= theta_valid_d;
      wrap_q        <= wrap_d;
      freq_ack_q    <= freq_ack_d;
    end
  end

  assign theta_o       = theta_q;
  assign theta_valid_o = theta_valid_q;
  assign wrap_o        = wrap_q;
  assign freq_ack_o    = freq_ack_q;

endmodule

// File: tb/tb_nco_phase_acc.sv
// Self-checking bench for nco_phase_acc: an arithmetic reference model compared every cycle,
// directed scenarios with literal expectations, a dither-bound sweep and a randomized phase.
module tb_nco_phase_acc;

  localparam int AW = 32;
  localparam int OW = 10;
  localparam int DW = 6;
  localparam int TW = OW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [AW-1:0] word = '0;
  logic [OW-1:0] off = '0;
  logic          sync = 1'b0;
  logic          dith = 1'b0;

  logic          freq_ack_o;
  logic [OW-1:0] theta_o;
  logic          theta_valid_o;
  logic          wrap_o;

  int n_checks = 0;
  int n_fail   = 0;

  nco_phase_acc #(.ACC_W(AW), .OUT_W(OW), .DITHER_W(DW), .LFSR_SEED(16'hACE1)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clk_en_i       (en),
    .freq_word_i    (word),
    .freq_load_i    (load),
    .freq_ack_o     (freq_ack_o),
    .phase_offset_i (off),
    .phase_sync_i   (sync),
    .dither_en_i    (dith),
    .theta_o        (theta_o),
    .theta_valid_o  (theta_valid_o),
    .wrap_o         (wrap_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  longint m_acc, m_active, m_shadow;
  bit     m_pending;
  int     m_lfsr;
  int     m_theta, m_und;
  bit     m_valid, m_wrap, m_ack;

  function automatic int lfsr_next(input int s);
    return (s % 2 == 1) ? ((s / 2) ^ 'hB400) : (s / 2);
  endfunction

  function automatic int theta_of(input longint acc, input int lfsr, input bit d, input int o);
    longint top, t;
    top = acc / (64'd1 << (AW - TW));
    t   = (top + (d ? longint'(lfsr % (1 << DW)) : 64'd0)) % (64'd1 << TW);
    return int'(((t / (64'd1 << DW)) + longint'(o)) % (64'd1 << OW));
  endfunction

  task automatic model_update();
    longint s;
    if (rst) begin
      m_acc = 0; m_active = 0; m_shadow = 0; m_pending = 0;
      m_lfsr = 'hACE1; m_theta = 0; m_und = 0;
      m_valid = 0; m_wrap = 0; m_ack = 0;
    end else begin
      m_valid = en;
      m_ack   = en && m_pending;
      m_wrap  = 0;
      if (en) begin
        m_theta = theta_of(m_acc, m_lfsr, dith, int'(off));
        m_und   = theta_of(m_acc, m_lfsr, 1'b0, int'(off));
        s = m_acc + m_active;
        if (sync) m_acc = 0;
        else begin
          m_wrap = (s >= (64'd1 << AW));
          m_acc  = s % (64'd1 << AW);
        end
        m_lfsr = lfsr_next(m_lfsr);
        if (m_pending) begin
          m_active  = m_shadow;
          m_pending = 0;
        end
      end
      if (load) begin
        m_shadow  = longint'(word);
        m_pending = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_update();
    #1;
    check("theta", 32'(theta_o), 32'(m_theta));
    check("theta_valid", 32'(theta_valid_o), 32'(m_valid));
    check("wrap", 32'(wrap_o), 32'(m_wrap));
    check("freq_ack", 32'(freq_ack_o), 32'(m_ack));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Park the model-visible inputs, load a word, then transfer it while zeroing the accumulator.
  task automatic load_and_sync(input logic [AW-1:0] w);
    en = 1'b0; load = 1'b1; word = w;
    step();
    load = 1'b0; en = 1'b1; sync = 1'b1;
    step();
    sync = 1'b0;
  endtask

  initial begin
    int wraps, valids, th;
    logic [OW-1:0] diff;

    repeat (2) step();
    check("reset_theta", 32'(theta_o), 32'h0);
    check("reset_valid", 32'(theta_valid_o), 32'h0);
    check("reset_ack", 32'(freq_ack_o), 32'h0);
    check("reset_wrap", 32'(wrap_o), 32'h0);

    // 1: step of 4 LSB, FreqAck once
    rst = 1'b0; en = 1'b0; load = 1'b1; word = 32'h0100_0000;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check("t1_ack_pulse", 32'(freq_ack_o), 32'h1);
    check("t1_theta0", 32'(theta_o), 32'h0);
    check("lfsr_first_step", 32'(m_lfsr), 32'hE270);
    step();
    check("t1_ack_done", 32'(freq_ack_o), 32'h0);
    check("t1_theta1", 32'(theta_o), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("t1_theta_step", 32'(theta_o), 32'(4 * i));
      check("t1_valid", 32'(theta_valid_o), 32'h1);
    end

    // 2: quarter-turn steps and wrap cadence
    load_and_sync(32'h4000_0000);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_theta", 32'(theta_o), 32'((i % 4) * 256));
      check("t2_wrap", 32'(wrap_o), (i == 3) ? 32'h1 : 32'h0);
    end
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (wrap_o === 1'b1) wraps++;
    end
    check("t2_wrap_count", 32'(wraps), 32'd4);

    // 3: enable 1-in-3, Theta steps by 1 and holds in between
    load_and_sync(32'h0040_0000);
    valids = 0;
    for (int k = 0; k < 10; k++) begin
      en = 1'b1;
      step();
      th = int'(theta_o);
      check("t3_theta_inc", 32'(th), 32'(k));
      if (theta_valid_o === 1'b1) valids++;
      en = 1'b0;
      for (int j = 0; j < 2; j++) begin
        step();
        check("t3_hold", 32'(theta_o), 32'(th));
        if (theta_valid_o === 1'b1) valids++;
      end
    end
    check("t3_valid_count", 32'(valids), 32'd10);

    // 4: offset path and modulo wrap of the offset add
    off = 10'h300;
    load_and_sync(32'h0);
    step(); step();
    check("t4_offset_only", 32'(theta_o), 32'h300);
    off = 10'h3FF;
    load_and_sync(32'h0040_0000);
    step();
    check("t4_offset_3ff", 32'(theta_o), 32'h3FF);
    step();
    check("t4_offset_wrap", 32'(theta_o), 32'h000);
    off = '0;

    // 5: PhaseSync mid-run
    load_and_sync(32'h0100_0000);
    repeat (6) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_after_sync", 32'(theta_o), 32'(4 * i));
      check("t5_no_wrap", 32'(wrap_o), 32'h0);
    end

    // 6a: dither bound over 4096 enabled cycles
    dith = 1'b1;
    load_and_sync(32'h0001_0000);
    for (int i = 0; i < 4096; i++) begin
      step();
      diff = theta_o - OW'(m_und);
      check("t6_dither_bound", 32'(diff <= 10'd1 || diff == 10'h3FF), 32'h1);
      check("t6_lfsr_nonzero", 32'(m_lfsr != 0), 32'h1);
    end
    dith = 1'b0;

    // 6b: reset discards a pending load (separately and in the same cycle)
    en = 1'b0; load = 1'b1; word = 32'h1234_5678;
    step();
    load = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_no_ack", 32'(freq_ack_o), 32'h0);
      check("t6_theta_frozen", 32'(theta_o), 32'h0);
    end
    rst = 1'b1; load = 1'b1; word = 32'h0000_0055;
    step();
    rst = 1'b0; load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_rst_load_ack", 32'(freq_ack_o), 32'h0);
    end

    // randomized phase, checked by the per-cycle model compare
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 15) == 0);
      word = $urandom;
      off  = OW'($urandom);
      sync = ($urandom_range(0, 63) == 0);
      dith = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; en = 1'b0; load = 1'b0; sync = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nco_phase_acc.md
Name: nco_phase_acc

Overview:
Numerically controlled oscillator phase generator that drives the 10-bit Theta input of the quadrant-folded sine/cosine LUT stage in the SDR receive path.
- Accumulates a 32-bit tuning word on every enabled cycle.
- Applies optional LFSR phase dither and a programmable phase offset.
- Truncates the result to OUT_W bits.
- Tuning-word updates from the CSR side are double-buffered so frequency changes land glitch-free on an enabled cycle.

Parameters:
ACC_W, 32, phase accumulator width; Theta resolution = 2^-ACC_W turn per LSB of FreqWord
OUT_W, 10, output phase width (matches LUT stage Theta)
DITHER_W, 6, accumulator bits below the truncation point that receive dither; constraints: DITHER_W<=16, OUT_W+DITHER_W<=ACC_W
LFSR_SEED, 16'hACE1, dither LFSR reset value; must be nonzero

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
ClkEn  in  1  sample-rate enable; state advances only when high
FreqWord  in  ACC_W  tuning word, unsigned
FreqLoad  in  1  one-cycle strobe; captures FreqWord into the shadow register
FreqAck  out  1  one-cycle pulse: shadow value transferred to the active register
PhaseOffset  in  OUT_W  added to the truncated phase, modulo 2^OUT_W
PhaseSync  in  1  zeroes the accumulator on the next ClkEn cycle
DitherEn  in  1  enables LFSR dither
Theta  out  OUT_W  output phase to the LUT stage
ThetaValid  out  1  high for one Clock after each ClkEn cycle (Theta updated)
Wrap  out  1  one-Clock pulse after an accumulator carry-out

Behaviour:
- Reset (overrides everything, including a FreqLoad in the same cycle):
  - acc, active_freq, shadow and pending cleared to 0.
  - lfsr set to LFSR_SEED.
  - Theta, ThetaValid, FreqAck and Wrap driven to 0.
- Shadow load (independent of ClkEn):
  - FreqLoad=1: shadow<=FreqWord and pending<=1.
  - A later load before transfer overwrites shadow.
- Transfer: on a ClkEn cycle with pending=1, active_freq<=shadow and pending<=0. FreqAck=1 in the following Clock only.
- Transfer and FreqLoad in the same cycle: active_freq takes the OLD shadow; shadow takes the new word; pending stays 1; FreqAck still pulses.
- Accumulator, on ClkEn:
  - PhaseSync=1: acc<=0. No Wrap. PhaseSync has priority over the increment.
  - Otherwise acc<=acc+active_freq, modulo 2^ACC_W.
  - The increment uses active_freq as it was before any same-cycle transfer. A new frequency takes effect on the next ClkEn.
- Wrap: registered carry-out of the addition. High for exactly one Clock after the carrying ClkEn cycle.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts on every ClkEn.
  - Never reaches 0.
- Output stage, on ClkEn:
  - t = acc[ACC_W-1 -: OUT_W+DITHER_W] + (DitherEn ? lfsr[DITHER_W-1:0] : 0), modulo 2^(OUT_W+DITHER_W).
  - Theta <= t[top OUT_W bits] + PhaseOffset, modulo 2^OUT_W.
  - acc here is the registered value before this cycle's update, so Theta lags acc by one ClkEn. Total latency from FreqLoad to first Theta step is 3 ClkEn cycles: transfer, increment, output.
- ThetaValid<=ClkEn (0 during Reset). It is used as the downstream LUT stage's ClkEn.
- Holding: with ClkEn=0, acc, lfsr, active_freq and Theta hold. ThetaValid, Wrap and FreqAck return to 0 after their single pulse.
- Reset mid-operation: a pending shadow load is discarded; the Theta sequence restarts from 0 + PhaseOffset offset path.
- FreqWord=0 yields constant Theta = PhaseOffset when DitherEn=0.

Test Plan:
1. Reset; FreqLoad with 0x01000000; ClkEn=1 continuous; DitherEn=0; PhaseOffset=0.
   - FreqAck pulses once.
   - Theta: 0,0,4,8,12… (step 4 LSB); ThetaValid constantly 1.
2. FreqWord=0x40000000, ClkEn continuous.
   - Theta cycles 0,256,512,768,0.
   - Wrap pulses once every 4 ClkEn cycles, aligned to the 768->0 transition cycle of acc.
3. ClkEn high 1 cycle in 3, FreqWord=0x00400000.
   - Theta increments by 1 only after enabled cycles.
   - ThetaValid pulses 1-in-3; no change while ClkEn=0.
4. FreqWord=0, PhaseOffset=0x300 -> Theta=0x300. Then acc top bits=0x001 with PhaseOffset=0x3FF -> Theta=0x000 (modulo wrap).
5. PhaseSync pulse mid-run at FreqWord=0x01000000 -> next Theta=PhaseOffset, then steps of 4 resume; no Wrap.
6. Dither and reset checks:
   - DitherEn=1, FreqWord=0x00010000: over 4096 ClkEn, |Theta-undithered|<=1 LSB every sample and LFSR never 0.
   - FreqLoad followed by Reset before transfer -> no FreqAck; active_freq stays 0.
